multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, instruction/data memory port, register file, ALU and its operand multiplexers) through fetch, decode, execute, memory and writeback steps. It drives every mux select and write enable, including the 2-bit ALU operand-B select (register / immediate / constant 4), and stalls on a ready handshake from the memory port. The supported instruction subset is R-type, I-type ALU, lw, sw/sh, beq and jal.

---
 rtl/riscv_ctrl_pkg.sv | 58 +++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 149 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I control path.
// Holds the supported opcodes, the 4-bit FSM state encoding, the datapath mux
// select constants, the internal ALU operation classes and the ALU control codes.
package riscv_ctrl_pkg;

  // Supported opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10
  } state_e;

  // ALU operand A select
  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_REG   = 2'b10;

  // ALU operand B select (2'b11 is never driven)
  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

  // Writeback / PC result select
  localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
  localparam logic [1:0] RESULT_MEMDATA = 2'b01;
  localparam logic [1:0] RESULT_ALURES  = 2'b10;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTRL_AND = 3'b010;
  localparam logic [2:0] ALU_CTRL_OR  = 3'b011;
  localparam logic [2:0] ALU_CTRL_XOR = 3'b100;
  localparam logic [2:0] ALU_CTRL_SLT = 3'b101;
  localparam logic [2:0] ALU_CTRL_SLL = 3'b110;
  localparam logic [2:0] ALU_CTRL_SRL = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control FSM and the shared datapath.
//   Instruction fields and mem_ready flow from the datapath into the controller;
//   all mux selects, write enables and status pulses flow back out.
//   modport master : controller side (drives controls)
//   modport slave  : datapath side (drives instruction fields and mem_ready)
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       mem_ready;

  logic       pc_write;
  logic       branch;
  logic       ir_write;
  logic       adr_src;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
    input  opcode, funct3, funct7_5, mem_ready,
    output pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_control, instr_done, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7_5, mem_ready,
    input  pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_control, instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: combinational map from operation class + funct fields to the
// 3-bit ALU control code.
//   alu_op_i      : ALU_OP_ADD / ALU_OP_SUB / ALU_OP_FUNCT
//   funct3_i      : instr[14:12]
//   funct7_5_i    : instr[30]
//   op5_i         : opcode bit 5 (1 = R-type, 0 = I-type when decoding funct)
//   alu_control_o : ALU_CTRL_* code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_CTRL_ADD;
    case (alu_op_i)
      ALU_OP_SUB: alu_control_o = ALU_CTRL_SUB;
      ALU_OP_FUNCT: begin
        case (funct3_i)
          // Only R-type uses funct7_5 to select sub; addi with instr[30]=1
          // must remain an add.
          3'b000:  alu_control_o = (op5_i && funct7_5_i) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
          3'b001:  alu_control_o = ALU_CTRL_SLL;
          3'b010:  alu_control_o = ALU_CTRL_SLT;
          3'b100:  alu_control_o = ALU_CTRL_XOR;
          // No arithmetic shift in this ALU: srl and sra both map to srl.
          3'b101:  alu_control_o = ALU_CTRL_SRL;
          3'b110:  alu_control_o = ALU_CTRL_OR;
          3'b111:  alu_control_o = ALU_CTRL_AND;
          default: alu_control_o = ALU_CTRL_ADD;
        endcase
      end
      default: alu_control_o = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences fetch / decode / execute / memory / writeback for R-type, I-type
// ALU, lw, sw/sh, beq and jal, stalling on mem_ready in FETCH, MEM_READ and
// MEM_WRITE. The state register is the only flop; all outputs are
// combinational from state plus mem_ready/opcode.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, forces FETCH
//   bus   : multicycle_ctrl_if.master (instruction fields, mem_ready in;
//           selects, enables, instr_done, illegal_instr out)
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_ctrl_if.master        bus
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = bus.opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BEQ:       state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.branch        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.adr_src       = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = ALU_SRC_A_PC;
    bus.alu_src_b     = ALU_SRC_B_REG;
    bus.result_src    = RESULT_ALUOUT;
    bus.instr_done    = 1'b0;
    bus.illegal_instr = 1'b0;
    alu_op            = ALU_OP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the live ALU result into the PC.
        bus.mem_read   = 1'b1;
        bus.alu_src_a  = ALU_SRC_A_PC;
        bus.alu_src_b  = ALU_SRC_B_FOUR;
        bus.result_src = RESULT_ALURES;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        // old_pc + imm lands in ALUOut as the branch/jal target.
        bus.alu_src_a = ALU_SRC_A_OLDPC;
        bus.alu_src_b = ALU_SRC_B_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: ;
          default: begin
            bus.illegal_instr = 1'b1;
            bus.instr_done    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = ALU_SRC_A_REG;
        bus.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_READ: begin
        bus.adr_src  = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        bus.result_src = RESULT_MEMDATA;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.adr_src    = 1'b1;
        bus.mem_write  = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_EXEC_R: begin
        bus.alu_src_a = ALU_SRC_A_REG;
        bus.alu_src_b = ALU_SRC_B_REG;
        alu_op        = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        bus.alu_src_a = ALU_SRC_A_REG;
        bus.alu_src_b = ALU_SRC_B_IMM;
        alu_op        = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        bus.result_src = RESULT_ALUOUT;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a  = ALU_SRC_A_REG;
        bus.alu_src_b  = ALU_SRC_B_REG;
        alu_op         = ALU_OP_SUB;
        bus.result_src = RESULT_ALUOUT;
        bus.branch     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value.
        bus.alu_src_a  = ALU_SRC_A_OLDPC;
        bus.alu_src_b  = ALU_SRC_B_FOUR;
        bus.result_src = RESULT_ALUOUT;
        bus.pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .funct7_5_i    (bus.funct7_5),
    .op5_i         (bus.opcode[5]),
    .alu_control_o (bus.alu_control)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [2:0] alu;
    logic       done;
    logic       ill;
  } obs_t;

  obs_t obs [1:16];

  // Drive one instruction for n cycles; bit k-1 of rdy is mem_ready in cycle k.
  // Outputs are captured on the falling edge of each cycle.
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                     input logic [15:0] rdy, input int n);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f75;
    for (int k = 1; k <= n; k++) begin
      bus.mem_ready = rdy[k-1];
      @(negedge clk);
      obs[k].pc_write  = bus.pc_write;
      obs[k].branch    = bus.branch;
      obs[k].ir_write  = bus.ir_write;
      obs[k].adr_src   = bus.adr_src;
      obs[k].mem_read  = bus.mem_read;
      obs[k].mem_write = bus.mem_write;
      obs[k].reg_write = bus.reg_write;
      obs[k].a         = bus.alu_src_a;
      obs[k].b         = bus.alu_src_b;
      obs[k].res       = bus.result_src;
      obs[k].alu       = bus.alu_control;
      obs[k].done      = bus.instr_done;
      obs[k].ill       = bus.illegal_instr;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    int ndone;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 7'b0110011;
    bus.funct3 = 3'b000;
    bus.funct7_5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.mem_read, bus.alu_src_b, bus.alu_src_a, bus.result_src, bus.alu_control, bus.adr_src} !== {1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {bus.mem_read, bus.alu_src_b, bus.alu_src_a, bus.result_src, bus.alu_control, bus.adr_src}, 12'b1_10_00_10_000_0);
    end
    checks++;
    if ({bus.pc_write, bus.branch, bus.ir_write, bus.mem_write, bus.reg_write, bus.instr_done, bus.illegal_instr} !== 7'b0) begin
      failures++;
      $display("FAIL reset_enables got=%b exp=0000000", {bus.pc_write, bus.branch, bus.ir_write, bus.mem_write, bus.reg_write, bus.instr_done, bus.illegal_instr});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Released with mem_ready low: FETCH must hold.
    run(7'b0110011, 3'b000, 1'b0, 16'h0000, 3);
    ndone = 0;
    for (int k = 1; k <= 3; k++) ndone += int'(obs[k].done);
    checks++;
    if (obs[3].mem_read !== 1'b1 || obs[3].b !== 2'b10 || obs[3].ir_write !== 1'b0 || ndone != 0) begin
      failures++;
      $display("FAIL reset_hold_fetch got=%b,%b,%b,%0d exp=1,10,0,0", obs[3].mem_read, obs[3].b, obs[3].ir_write, ndone);
    end
    // lw stalled in MEM_READ, then reset.
    run(7'b0000011, 3'b010, 1'b0, 16'h0001, 4);
    checks++;
    if (obs[4].adr_src !== 1'b1 || obs[4].mem_read !== 1'b1 || obs[4].done !== 1'b0) begin
      failures++;
      $display("FAIL reset_memread_wait got=%b%b%b exp=110", obs[4].adr_src, obs[4].mem_read, obs[4].done);
    end
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.adr_src, bus.mem_read, bus.alu_src_b, bus.result_src, bus.reg_write, bus.instr_done} !== {1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_abort_wait got=%b exp=%b", {bus.adr_src, bus.mem_read, bus.alu_src_b, bus.result_src, bus.reg_write, bus.instr_done}, 8'b0_1_10_10_0_0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    int ndone;
    // sub
    run(7'b0110011, 3'b000, 1'b1, 16'h000F, 5);
    checks++;
    if (obs[1].ir_write !== 1'b1 || obs[1].pc_write !== 1'b1 || obs[1].res !== 2'b10) begin
      failures++;
      $display("FAIL fetch_ready got=%b%b,%b exp=11,10", obs[1].ir_write, obs[1].pc_write, obs[1].res);
    end
    checks++;
    if (obs[2].a !== 2'b01 || obs[2].b !== 2'b01 || obs[2].alu !== 3'b000) begin
      failures++;
      $display("FAIL decode_sel got=%b,%b,%b exp=01,01,000", obs[2].a, obs[2].b, obs[2].alu);
    end
    checks++;
    if (obs[3].a !== 2'b10 || obs[3].b !== 2'b00 || obs[3].alu !== 3'b001) begin
      failures++;
      $display("FAIL sub_exec got=%b,%b,%b exp=10,00,001", obs[3].a, obs[3].b, obs[3].alu);
    end
    ndone = 0;
    for (int k = 1; k <= 4; k++) ndone += int'(obs[k].done);
    checks++;
    if (obs[4].reg_write !== 1'b1 || obs[4].done !== 1'b1 || obs[4].res !== 2'b00 || ndone != 1) begin
      failures++;
      $display("FAIL sub_wb got=%b%b,%b,%0d exp=11,00,1", obs[4].reg_write, obs[4].done, obs[4].res, ndone);
    end
    checks++;
    if (obs[5].mem_read !== 1'b1 || obs[5].b !== 2'b10 || obs[5].reg_write !== 1'b0) begin
      failures++;
      $display("FAIL sub_back_to_fetch got=%b,%b,%b exp=1,10,0", obs[5].mem_read, obs[5].b, obs[5].reg_write);
    end
    // addi with instr[30]=1 must stay add
    run(7'b0010011, 3'b000, 1'b1, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b000 || obs[3].b !== 2'b01 || obs[4].done !== 1'b1) begin
      failures++;
      $display("FAIL addi_f7 got=%b,%b,%b exp=000,01,1", obs[3].alu, obs[3].b, obs[4].done);
    end
    // xori, R-type sra (maps to srl), and/or, unsupported funct3=011
    run(7'b0010011, 3'b100, 1'b0, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b100) begin
      failures++;
      $display("FAIL xori got=%b exp=100", obs[3].alu);
    end
    run(7'b0110011, 3'b101, 1'b1, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b111) begin
      failures++;
      $display("FAIL sra got=%b exp=111", obs[3].alu);
    end
    run(7'b0110011, 3'b111, 1'b0, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b010) begin
      failures++;
      $display("FAIL and got=%b exp=010", obs[3].alu);
    end
    run(7'b0010011, 3'b110, 1'b0, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b011) begin
      failures++;
      $display("FAIL ori got=%b exp=011", obs[3].alu);
    end
    run(7'b0010011, 3'b001, 1'b0, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b110) begin
      failures++;
      $display("FAIL slli got=%b exp=110", obs[3].alu);
    end
    run(7'b0110011, 3'b010, 1'b0, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b101) begin
      failures++;
      $display("FAIL slt got=%b exp=101", obs[3].alu);
    end
    run(7'b0110011, 3'b011, 1'b1, 16'h000F, 4);
    checks++;
    if (obs[3].alu !== 3'b000 || obs[3].ill !== 1'b0 || obs[4].done !== 1'b1) begin
      failures++;
      $display("FAIL f3_011 got=%b,%b,%b exp=000,0,1", obs[3].alu, obs[3].ill, obs[4].done);
    end
  endtask

  task automatic test_load_waits();
    int ndone;
    // FETCH waits 2, MEM_READ waits 3 -> done in cycle 10
    run(7'b0000011, 3'b010, 1'b0, 16'h031C, 11);
    checks++;
    if (obs[2].mem_read !== 1'b1 || obs[2].ir_write !== 1'b0 || obs[3].ir_write !== 1'b1) begin
      failures++;
      $display("FAIL lw_fetch_wait got=%b%b%b exp=101", obs[2].mem_read, obs[2].ir_write, obs[3].ir_write);
    end
    checks++;
    if (obs[5].b !== 2'b01 || obs[5].a !== 2'b10 || obs[5].alu !== 3'b000) begin
      failures++;
      $display("FAIL lw_memaddr got=%b,%b,%b exp=01,10,000", obs[5].b, obs[5].a, obs[5].alu);
    end
    checks++;
    if (obs[6] !== obs[8] || obs[8].adr_src !== 1'b1 || obs[9].mem_read !== 1'b1) begin
      failures++;
      $display("FAIL lw_memread_stable got=%h/%h exp adr_src=1", obs[6], obs[8]);
    end
    ndone = 0;
    for (int k = 1; k <= 9; k++) ndone += int'(obs[k].done);
    checks++;
    if (obs[10].done !== 1'b1 || obs[10].res !== 2'b01 || obs[10].reg_write !== 1'b1 || ndone != 0) begin
      failures++;
      $display("FAIL lw_wb got=%b,%b,%b,%0d exp=1,01,1,0", obs[10].done, obs[10].res, obs[10].reg_write, ndone);
    end
    checks++;
    if (obs[11].mem_read !== 1'b1 || obs[11].adr_src !== 1'b0 || obs[11].done !== 1'b0) begin
      failures++;
      $display("FAIL lw_next_fetch got=%b%b%b exp=100", obs[11].mem_read, obs[11].adr_src, obs[11].done);
    end
  endtask

  task automatic test_store_branch();
    // sh
    run(7'b0100011, 3'b001, 1'b0, 16'h000F, 5);
    checks++;
    if (obs[3].b !== 2'b01 || obs[3].mem_write !== 1'b0) begin
      failures++;
      $display("FAIL sh_memaddr got=%b,%b exp=01,0", obs[3].b, obs[3].mem_write);
    end
    checks++;
    if (obs[4].mem_write !== 1'b1 || obs[4].adr_src !== 1'b1 || obs[4].done !== 1'b1 || obs[4].mem_read !== 1'b0) begin
      failures++;
      $display("FAIL sh_write got=%b%b%b%b exp=1110", obs[4].mem_write, obs[4].adr_src, obs[4].done, obs[4].mem_read);
    end
    checks++;
    if (obs[5].mem_read !== 1'b1 || obs[5].mem_write !== 1'b0) begin
      failures++;
      $display("FAIL sh_next_fetch got=%b%b exp=10", obs[5].mem_read, obs[5].mem_write);
    end
    // sw with one MEM_WRITE wait: done only in the ready cycle
    run(7'b0100011, 3'b010, 1'b0, 16'h0017, 5);
    checks++;
    if (obs[4].mem_write !== 1'b1 || obs[4].done !== 1'b0 || obs[5].done !== 1'b1 || obs[5].mem_write !== 1'b1) begin
      failures++;
      $display("FAIL sw_wait got=%b%b%b%b exp=1011", obs[4].mem_write, obs[4].done, obs[5].done, obs[5].mem_write);
    end
    // beq
    run(7'b1100011, 3'b000, 1'b0, 16'h0007, 4);
    checks++;
    if (obs[3].branch !== 1'b1 || obs[3].alu !== 3'b001 || obs[3].b !== 2'b00 || obs[3].done !== 1'b1 || obs[3].pc_write !== 1'b0) begin
      failures++;
      $display("FAIL beq got=%b,%b,%b,%b,%b exp=1,001,00,1,0", obs[3].branch, obs[3].alu, obs[3].b, obs[3].done, obs[3].pc_write);
    end
    checks++;
    if (obs[4].mem_read !== 1'b1 || obs[4].branch !== 1'b0) begin
      failures++;
      $display("FAIL beq_next_fetch got=%b%b exp=10", obs[4].mem_read, obs[4].branch);
    end
  endtask

  task automatic test_jal();
    run(7'b1101111, 3'b000, 1'b0, 16'h000F, 5);
    checks++;
    if (obs[3].pc_write !== 1'b1 || obs[3].a !== 2'b01 || obs[3].b !== 2'b10 || obs[3].res !== 2'b00 || obs[3].done !== 1'b0) begin
      failures++;
      $display("FAIL jal_exec got=%b,%b,%b,%b,%b exp=1,01,10,00,0", obs[3].pc_write, obs[3].a, obs[3].b, obs[3].res, obs[3].done);
    end
    checks++;
    if (obs[4].reg_write !== 1'b1 || obs[4].res !== 2'b00 || obs[4].done !== 1'b1 || obs[4].pc_write !== 1'b0) begin
      failures++;
      $display("FAIL jal_wb got=%b,%b,%b,%b exp=1,00,1,0", obs[4].reg_write, obs[4].res, obs[4].done, obs[4].pc_write);
    end
  endtask

  task automatic test_illegal();
    run(7'b1110011, 3'b000, 1'b0, 16'h0003, 3);
    checks++;
    if (obs[2].ill !== 1'b1 || obs[2].done !== 1'b1 || obs[1].ill !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse got=%b%b%b exp=110", obs[2].ill, obs[2].done, obs[1].ill);
    end
    checks++;
    if (obs[3].mem_read !== 1'b1 || obs[3].b !== 2'b10 || obs[3].ill !== 1'b0 || obs[3].done !== 1'b0) begin
      failures++;
      $display("FAIL illegal_next_fetch got=%b,%b,%b,%b exp=1,10,0,0", obs[3].mem_read, obs[3].b, obs[3].ill, obs[3].done);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_waits();
    test_store_branch();
    test_jal();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
